// File: rtl/coin_acceptor_if.sv
// Coin-slot bundle: raw sensor levels and control in, clean coin pulses and bookkeeping out.
// The acceptor uses the slave view; whoever drives the sensors uses the master view.
interface coin_acceptor_if;
  logic       raw_ci1, raw_ci5, raw_ci10, raw_ci50, raw_ci100;
  logic       accept;
  logic       clr;
  logic       ci1, ci5, ci10, ci50, ci100;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       rej;
  logic       busy;
  logic [7:0] total;
  logic       sat;
  logic       lost;

  modport master (
    output raw_ci1, raw_ci5, raw_ci10, raw_ci50, raw_ci100, accept, clr,
    input  ci1, ci5, ci10, ci50, ci100, coin_valid, coin_value, rej, busy, total, sat, lost
  );

  modport slave (
    input  raw_ci1, raw_ci5, raw_ci10, raw_ci50, raw_ci100, accept, clr,
    output ci1, ci5, ci10, ci50, ci100, coin_valid, coin_value, rej, busy, total, sat, lost
  );
endinterface

// File: rtl/coin_acceptor.sv
// Debounces five coin sensors and serialises coins into one-cycle pulses, DEBOUNCE_CYCLES+3 edges after raw rise.
// No backpressure: coins queue in one pending bit per channel; a repeat on a full bit is dropped and flagged lost.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic           clk_sys,
  input  logic           rst,
  coin_acceptor_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  logic [4:0]    raw;
  logic [4:0]    meta_q, sync_q;
  logic [4:0]    deb_q, deb_d;
  logic [4:0]    det, acc_det;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]    pend_q, pend_d;
  logic [4:0]    sel, pulse_q;
  logic          emit;
  logic [7:0]    value_d, value_q;
  logic [7:0]    total_q, total_d;
  logic [8:0]    sum9;
  logic          rej_q, rej_d;
  logic          sat_q, sat_d;
  logic          lost_q, lost_d;
  logic          lost_evt;

  // Bit 0 is the 1-yuan slot so the lowest set bit is also the highest priority.
  assign raw = {bus.raw_ci100, bus.raw_ci50, bus.raw_ci10, bus.raw_ci5, bus.raw_ci1};

  always_comb begin
    deb_d = deb_q;
    det   = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_q[i];
          det[i]   = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    sel     = '0;
    emit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          emit    = 1'b1;
          sel     = pend_q & (~pend_q + 5'd1);
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      default: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = S_IDLE;
      end
    endcase

    case (sel)
      5'b00001: value_d = 8'd1;
      5'b00010: value_d = 8'd5;
      5'b00100: value_d = 8'd10;
      5'b01000: value_d = 8'd50;
      5'b10000: value_d = 8'd100;
      default:  value_d = 8'd0;
    endcase

    // A detection on the bit being emitted this edge simply re-arms it.
    acc_det  = det & {5{bus.accept}};
    pend_d   = (pend_q & ~sel) | acc_det;
    lost_evt = |(acc_det & pend_q & ~sel);
    rej_d    = (|det) & ~bus.accept;

    sum9    = {1'b0, total_q} + {1'b0, value_d};
    total_d = total_q;
    sat_d   = sat_q;
    if (bus.clr) begin
      total_d = value_d;
      sat_d   = 1'b0;
    end else if (emit) begin
      if (sum9[8]) begin
        total_d = 8'hFF;
        sat_d   = 1'b1;
      end else begin
        total_d = sum9[7:0];
      end
    end
    lost_d = (lost_q & ~bus.clr) | lost_evt;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      state_q <= S_IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      pulse_q <= '0;
      value_q <= '0;
      total_q <= '0;
      rej_q   <= 1'b0;
      sat_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      pulse_q <= sel;
      value_q <= value_d;
      total_q <= total_d;
      rej_q   <= rej_d;
      sat_q   <= sat_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.ci1        = pulse_q[0];
  assign bus.ci5        = pulse_q[1];
  assign bus.ci10       = pulse_q[2];
  assign bus.ci50       = pulse_q[3];
  assign bus.ci100      = pulse_q[4];
  assign bus.coin_valid = |pulse_q;
  assign bus.coin_value = value_q;
  assign bus.rej        = rej_q;
  assign bus.busy       = (|pend_q) | (gap_q != '0);
  assign bus.total      = total_q;
  assign bus.sat        = sat_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench: main instance uses D=4/GAP=2; a second instance with D=2/GAP=16 exercises lost coins and mid-gap reset.
module tb_coin_acceptor;
  logic clk_sys;
  logic rst;
  logic rst2;
  int   checks;
  int   bad;
  int   cyc;
  int   pv[$];
  int   pc[$];
  int   nrej;
  int   n2_any;
  int   n2_ci1;
  bit   multi_hot;

  coin_acceptor_if b1();
  coin_acceptor_if b2();

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2))  u_dut  (.clk_sys(clk_sys), .rst(rst),  .bus(b1));
  coin_acceptor #(.DEBOUNCE_CYCLES(2), .GAP_CYCLES(16)) u_dut2 (.clk_sys(clk_sys), .rst(rst2), .bus(b2));

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (b1.coin_valid) begin
      pv.push_back(int'(b1.coin_value));
      pc.push_back(cyc);
    end
    if ($countones({b1.ci1, b1.ci5, b1.ci10, b1.ci50, b1.ci100}) > 1) multi_hot = 1'b1;
    if (b1.rej) nrej++;
    if (b2.coin_valid) n2_any++;
    if (b2.ci1) n2_ci1++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    pv.delete();
    pc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_n(3);
    checks++; if ({b1.ci1, b1.ci5, b1.ci10, b1.ci50, b1.ci100} !== 5'b0) begin bad++; $display("FAIL reset_ci got=%b want=00000", {b1.ci1, b1.ci5, b1.ci10, b1.ci50, b1.ci100}); end
    checks++; if (b1.coin_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", b1.coin_valid); end
    checks++; if (b1.coin_value !== 8'd0) begin bad++; $display("FAIL reset_value got=%0d want=0", b1.coin_value); end
    checks++; if (b1.rej !== 1'b0) begin bad++; $display("FAIL reset_rej got=%b want=0", b1.rej); end
    checks++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b1.busy); end
    checks++; if (b1.total !== 8'd0) begin bad++; $display("FAIL reset_total got=%0d want=0", b1.total); end
    checks++; if (b1.sat !== 1'b0 || b1.lost !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b%b want=00", b1.sat, b1.lost); end
    rst = 1'b0;
    wait_n(4);
    checks++; if (b1.busy !== 1'b0 || b1.coin_valid !== 1'b0) begin bad++; $display("FAIL reset_idle got busy=%b valid=%b want=0 0", b1.busy, b1.coin_valid); end
  endtask

  task automatic test_single();
    do_reset();
    b1.raw_ci10 = 1'b1;
    wait_n(6);
    checks++; if (b1.ci10 !== 1'b0) begin bad++; $display("FAIL single_early ci10 got=%b want=0", b1.ci10); end
    checks++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL single_pending busy got=%b want=1", b1.busy); end
    wait_n(1);
    checks++; if (b1.ci10 !== 1'b1 || b1.coin_valid !== 1'b1) begin bad++; $display("FAIL single_pulse ci10=%b valid=%b want=1 1", b1.ci10, b1.coin_valid); end
    checks++; if (b1.coin_value !== 8'd10) begin bad++; $display("FAIL single_value got=%0d want=10", b1.coin_value); end
    checks++; if (b1.total !== 8'd10) begin bad++; $display("FAIL single_total got=%0d want=10", b1.total); end
    wait_n(1);
    checks++; if (b1.ci10 !== 1'b0 || b1.coin_value !== 8'd0) begin bad++; $display("FAIL single_width ci10=%b value=%0d want=0 0", b1.ci10, b1.coin_value); end
    wait_n(12);
    b1.raw_ci10 = 1'b0;
    wait_n(15);
    checks++; if (pv.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", pv.size()); end
    checks++; if (b1.total !== 8'd10 || b1.busy !== 1'b0) begin bad++; $display("FAIL single_final total=%0d busy=%b want=10 0", b1.total, b1.busy); end
  endtask

  task automatic test_glitch();
    bit busy_seen;
    do_reset();
    busy_seen = 1'b0;
    b1.raw_ci5 = 1'b1;
    wait_n(3);
    b1.raw_ci5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wait_n(1);
      if (b1.busy) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy_seen); end
    checks++; if (pv.size() != 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pv.size()); end
    b1.raw_ci5 = 1'b1;
    wait_n(4);
    b1.raw_ci5 = 1'b0;
    wait_n(3);
    checks++; if (b1.ci5 !== 1'b1 || b1.coin_value !== 8'd5) begin bad++; $display("FAIL glitch_edge ci5=%b value=%0d want=1 5", b1.ci5, b1.coin_value); end
    wait_n(12);
    checks++; if (pv.size() != 1) begin bad++; $display("FAIL glitch_edge_count got=%0d want=1", pv.size()); end
  endtask

  task automatic test_simultaneous();
    int c0;
    do_reset();
    multi_hot = 1'b0;
    c0 = cyc;
    b1.raw_ci100 = 1'b1;
    b1.raw_ci1   = 1'b1;
    b1.raw_ci50  = 1'b1;
    wait_n(20);
    b1.raw_ci100 = 1'b0;
    b1.raw_ci1   = 1'b0;
    b1.raw_ci50  = 1'b0;
    wait_n(15);
    checks++;
    if (pv.size() != 3) begin
      bad++; $display("FAIL simul_count got=%0d want=3", pv.size());
    end else begin
      checks++; if (pv[0] != 1 || pv[1] != 50 || pv[2] != 100) begin bad++; $display("FAIL simul_order got=%0d,%0d,%0d want=1,50,100", pv[0], pv[1], pv[2]); end
      checks++; if (pc[1] - pc[0] != 3 || pc[2] - pc[1] != 3) begin bad++; $display("FAIL simul_spacing got=%0d,%0d want=3,3", pc[1] - pc[0], pc[2] - pc[1]); end
      checks++; if (pc[0] - c0 != 7) begin bad++; $display("FAIL simul_latency got=%0d want=7", pc[0] - c0); end
    end
    checks++; if (b1.total !== 8'd151) begin bad++; $display("FAIL simul_total got=%0d want=151", b1.total); end
    checks++; if (multi_hot !== 1'b0) begin bad++; $display("FAIL simul_onehot got=%b want=0", multi_hot); end
  endtask

  task automatic test_saturation();
    int exp_total[3];
    bit exp_sat[3];
    exp_total = '{100, 200, 255};
    exp_sat   = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b1.raw_ci100 = 1'b1;
      wait_n(7);
      checks++; if (b1.ci100 !== 1'b1 || int'(b1.total) != exp_total[i]) begin bad++; $display("FAIL sat_total[%0d] ci100=%b total=%0d want=1 %0d", i, b1.ci100, b1.total, exp_total[i]); end
      checks++; if (b1.sat !== exp_sat[i]) begin bad++; $display("FAIL sat_flag[%0d] got=%b want=%b", i, b1.sat, exp_sat[i]); end
      wait_n(1);
      b1.raw_ci100 = 1'b0;
      wait_n(10);
    end
    b1.raw_ci5 = 1'b1;
    wait_n(6);
    checks++; if (b1.sat !== 1'b1 || b1.total !== 8'd255) begin bad++; $display("FAIL sat_hold sat=%b total=%0d want=1 255", b1.sat, b1.total); end
    b1.clr = 1'b1;
    wait_n(1);
    b1.clr = 1'b0;
    checks++; if (b1.ci5 !== 1'b1 || b1.total !== 8'd5) begin bad++; $display("FAIL sat_clr_total ci5=%b total=%0d want=1 5", b1.ci5, b1.total); end
    checks++; if (b1.sat !== 1'b0) begin bad++; $display("FAIL sat_clr_flag got=%b want=0", b1.sat); end
    wait_n(1);
    b1.raw_ci5 = 1'b0;
    wait_n(10);
  endtask

  task automatic test_reject();
    int n0;
    int r0;
    n0 = pv.size();
    r0 = nrej;
    b1.accept = 1'b0;
    b1.raw_ci50 = 1'b1;
    wait_n(5);
    checks++; if (b1.rej !== 1'b0) begin bad++; $display("FAIL rej_early got=%b want=0", b1.rej); end
    wait_n(1);
    checks++; if (b1.rej !== 1'b1) begin bad++; $display("FAIL rej_pulse got=%b want=1", b1.rej); end
    wait_n(1);
    checks++; if (b1.rej !== 1'b0) begin bad++; $display("FAIL rej_width got=%b want=0", b1.rej); end
    wait_n(10);
    b1.raw_ci50 = 1'b0;
    wait_n(10);
    checks++; if (nrej - r0 != 1) begin bad++; $display("FAIL rej_count got=%0d want=1", nrej - r0); end
    checks++; if (pv.size() != n0 || b1.total !== 8'd5) begin bad++; $display("FAIL rej_nocoin pulses=%0d total=%0d want=%0d 5", pv.size(), b1.total, n0); end
    b1.accept = 1'b1;
  endtask

  task automatic test_lost_reset();
    rst2 = 1'b0;
    wait_n(2);
    b2.raw_ci5 = 1'b1;
    wait_n(5);
    checks++; if (b2.ci5 !== 1'b1) begin bad++; $display("FAIL lost_holder ci5 got=%b want=1", b2.ci5); end
    b2.raw_ci5 = 1'b0;
    b2.raw_ci1 = 1'b1;
    wait_n(3);
    b2.raw_ci1 = 1'b0;
    wait_n(4);
    b2.raw_ci1 = 1'b1;
    wait_n(3);
    b2.raw_ci1 = 1'b0;
    checks++; if (b2.lost !== 1'b0) begin bad++; $display("FAIL lost_early got=%b want=0", b2.lost); end
    wait_n(1);
    checks++; if (b2.lost !== 1'b1) begin bad++; $display("FAIL lost_set got=%b want=1", b2.lost); end
    wait_n(6);
    checks++; if (b2.ci1 !== 1'b1 || b2.total !== 8'd6) begin bad++; $display("FAIL lost_emit ci1=%b total=%0d want=1 6", b2.ci1, b2.total); end
    wait_n(2);
    rst2 = 1'b1;
    wait_n(1);
    checks++; if ({b2.ci1, b2.ci5, b2.ci10, b2.ci50, b2.ci100, b2.coin_valid, b2.rej, b2.busy, b2.sat, b2.lost} !== 10'b0) begin bad++; $display("FAIL midgap_reset_flags got=%b want=0", {b2.ci1, b2.ci5, b2.ci10, b2.ci50, b2.ci100, b2.coin_valid, b2.rej, b2.busy, b2.sat, b2.lost}); end
    checks++; if (b2.total !== 8'd0 || b2.coin_value !== 8'd0) begin bad++; $display("FAIL midgap_reset_bus total=%0d value=%0d want=0 0", b2.total, b2.coin_value); end
    rst2 = 1'b0;
    wait_n(30);
    checks++; if (n2_ci1 != 1 || n2_any != 2) begin bad++; $display("FAIL lost_pulses ci1=%0d all=%0d want=1 2", n2_ci1, n2_any); end
  endtask

  initial begin
    checks = 0; bad = 0; cyc = 0; nrej = 0; n2_any = 0; n2_ci1 = 0; multi_hot = 1'b0;
    rst = 1'b1; rst2 = 1'b1;
    b1.raw_ci1 = 1'b0; b1.raw_ci5 = 1'b0; b1.raw_ci10 = 1'b0; b1.raw_ci50 = 1'b0; b1.raw_ci100 = 1'b0;
    b1.accept = 1'b1; b1.clr = 1'b0;
    b2.raw_ci1 = 1'b0; b2.raw_ci5 = 1'b0; b2.raw_ci10 = 1'b0; b2.raw_ci50 = 1'b0; b2.raw_ci100 = 1'b0;
    b2.accept = 1'b1; b2.clr = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_simultaneous();
    test_saturation();
    test_reject();
    test_lost_reset();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule
